mc_core: RTL and testbench
==========================

MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 Parameter DW, default 8: data/register width, min 4.
REQ-002 Parameter AW, default 6: PC/instruction address width, min 6.
REQ-003 Parameter NREG, default 8: register count, fixed at 8 (3-bit fields); other values rejected at elaboration.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 imem_req  out  1  fetch request.
REQ-007 imem_addr  out  AW  fetch address (= PC).
REQ-008 imem_ack  in  1  fetch done; imem_data valid this cycle.
REQ-009 imem_data  in  9  instruction word.
REQ-010 dmem_req  out  1  data access request.
REQ-011 dmem_we  out  1  1 = store, 0 = load.
REQ-012 dmem_addr  out  DW  data address.
REQ-013 dmem_wdata  out  DW  store data.
REQ-014 dmem_ack  in  1  access done; dmem_rdata valid this cycle for loads.
REQ-015 dmem_rdata  in  DW  load data.
REQ-016 halted  out  1  core is in HALT.
REQ-017 pc_out  out  AW  current PC, for debug.

Function
REQ-018 Instruction format: op=[8:6], rd=[5:3], rs/imm=[2:0], target=[5:0], zero-extended to AW.
REQ-019 Opcodes: 000 ADD rd+=R[rs]; 001 SUB rd-=R[rs]; 010 AND; 011 XOR; 100 ADDI rd+=zext(imm); 101 LD R[rd]=M[R[rs]]; 110 ST M[R[rs]]=R[rd]; 111 BZ: PC=target if R[0]==0, else PC+1.
REQ-020 Word 9'h1FF is HALT and takes precedence over BZ decoding.
REQ-021 All arithmetic is modulo 2^DW; no flags; PC+1 wraps modulo 2^AW.
REQ-022 FSM states: FETCH, EXEC, MEM, HALT.
REQ-023 FETCH: imem_req=1, imem_addr=PC held stable until imem_ack; on ack, latch IR, go EXEC; ack in the same cycle as req is legal.
REQ-024 EXEC with ALU/ADDI: write rd, PC+=1, go FETCH; with BZ: update PC, go FETCH; with LD/ST: go MEM; with HALT: go HALT, PC unchanged.
REQ-025 MEM: dmem_req=1; addr, we and wdata held stable until dmem_ack; on ack, LD writes dmem_rdata to rd, PC+=1, go FETCH.
REQ-026 Minimum CPI with zero-wait acks: 2 for ALU/BZ, 3 for LD/ST; each wait cycle adds one.
REQ-027 dmem_req and imem_req are never asserted together; each deasserts in the cycle after its ack.
REQ-028 HALT: no requests, halted=1, state held until reset.
REQ-029 Register writes occur only on the EXEC or MEM retire edge; reads use pre-write values (rd==rs legal).

Reset
REQ-030 reset low asynchronously: state=FETCH, PC=0, IR=0, all registers=0, imem_req=0, dmem_req=0, dmem_we=0, halted=0, counters=0.
REQ-031 A reset asserted mid-handshake abandons the access; no register or PC update from it.
REQ-032 First imem_req rises in the first cycle after reset deassertion.

Configuration
REQ-033 With macro MC_CORE_PERF_EN defined: outputs cycle_cnt[31:0] and instr_cnt[31:0] exist.
REQ-034 cycle_cnt increments every cycle not in HALT; instr_cnt increments on each retire (EXEC for ALU/BZ/HALT, MEM ack for LD/ST); both saturate at 32'hFFFFFFFF.
REQ-035 Without MC_CORE_PERF_EN: the ports and counters are absent; all other behaviour is identical.

Verification
REQ-036 DW=8, zero-wait memory; program ADDI r1,5; ADDI r1,7; HALT -> R1=12, halted after 5 cycles, pc_out=2.
REQ-037 R1=8'hFF, ADDI r1,1 -> R1=0 (wrap); SUB r2,r3 with R2=0,R3=1 -> R2=8'hFF.
REQ-038 R2=0x10, R3=0xAB; ST r3,(r2) with dmem_ack delayed 3 cycles -> dmem_addr=0x10, wdata=0xAB, we=1 held 4 cycles; then LD r4,(r2) returning 0xAB -> R4=0xAB.
REQ-039 R0=0, BZ 0x20 -> next fetch address 0x20; R0=1, same word -> next fetch PC+1; PC=63 with AW=6, ALU op -> next fetch address 0.
REQ-040 reset pulsed low during a wait-stated MEM cycle -> requests drop immediately, all registers 0, fetch restarts at 0.
REQ-041 MC_CORE_PERF_EN defined, program of REQ-036 -> instr_cnt=3, cycle_cnt=5, both frozen in HALT.

Source files
------------

// File: rtl/mc_core.sv
// mc_core: small multi-cycle 8-register core with 9-bit instructions.
//
// Each instruction passes through FETCH -> EXEC (-> MEM for LD/ST). Both memory ports use a
// req/ack handshake. Address, we and data stay stable while req is high. req drops in the
// cycle after ack.
//
// Parameters:
//   DW   - data/register width (>= 4)
//   AW   - PC / instruction address width (>= 6)
//   NREG - register count, must be 8
//
// Ports:
//   clk, reset              - rising-edge clock, asynchronous active-low reset
//   imem_req/addr/ack/data  - instruction fetch port (addr = PC)
//   dmem_req/we/addr/wdata  - data port request (we = 1 for store)
//   dmem_ack/rdata          - data port completion and load data
//   halted                  - core has reached HALT
//   pc_out                  - current PC
//   cycle_cnt, instr_cnt    - saturating performance counters (only with MC_CORE_PERF_EN)
//
// Optional feature macro: MC_CORE_PERF_EN adds the two performance counter outputs.
module mc_core #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 6,
  parameter int unsigned NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [8:0]    imem_data,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          halted,
  output logic [AW-1:0] pc_out
`ifdef MC_CORE_PERF_EN
  ,
  output logic [31:0]   cycle_cnt,
  output logic [31:0]   instr_cnt
`endif
);

  if (NREG != 8) begin : g_bad_nreg
    $error("mc_core: NREG must be 8");
  end
  if (DW < 4) begin : g_bad_dw
    $error("mc_core: DW must be at least 4");
  end
  if (AW < 6) begin : g_bad_aw
    $error("mc_core: AW must be at least 6");
  end

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpSub  = 3'd1;
  localparam logic [2:0] OpAnd  = 3'd2;
  localparam logic [2:0] OpXor  = 3'd3;
  localparam logic [2:0] OpLd   = 3'd5;
  localparam logic [2:0] OpSt   = 3'd6;
  localparam logic [2:0] OpBz   = 3'd7;
  localparam logic [8:0] HaltWord = 9'h1FF;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [8:0]    ir_q, ir_d;
  logic [DW-1:0] regs_q [8];

  logic          rf_we;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] alu_res;

  logic [2:0]    op, rd, rs;
  logic          is_halt, is_mem_op;
  logic [DW-1:0] rd_val, rs_val;
  logic [AW-1:0] pc_inc, target;

  assign op        = ir_q[8:6];
  assign rd        = ir_q[5:3];
  assign rs        = ir_q[2:0];
  assign is_halt   = (ir_q == HaltWord);
  assign is_mem_op = (op == OpLd) || (op == OpSt);
  assign rd_val    = regs_q[rd];
  assign rs_val    = regs_q[rs];
  assign pc_inc    = pc_q + AW'(1);
  assign target    = AW'(ir_q[5:0]);

  always_comb begin
    alu_res = rd_val + DW'(rs);
    case (op)
      OpAdd:   alu_res = rd_val + rs_val;
      OpSub:   alu_res = rd_val - rs_val;
      OpAnd:   alu_res = rd_val & rs_val;
      OpXor:   alu_res = rd_val ^ rs_val;
      default: alu_res = rd_val + DW'(rs);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_halt) begin
          state_d = StHalt;
        end else if (is_mem_op) begin
          state_d = StMem;
        end else if (op == OpBz) begin
          pc_d    = (regs_q[0] == '0) ? target : pc_inc;
          state_d = StFetch;
        end else begin
          rf_we   = 1'b1;
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      StMem: begin
        if (dmem_ack) begin
          rf_we    = (op == OpLd);
          rf_wdata = dmem_rdata;
          pc_d     = pc_inc;
          state_d  = StFetch;
        end
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      if (rf_we) begin
        regs_q[rd] <= rf_wdata;
      end
    end
  end

  // The reset state is FETCH, so the request is gated to stay low while reset is held.
  assign imem_req   = (state_q == StFetch) && reset;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == StMem);
  assign dmem_we    = dmem_req && (op == OpSt);
  assign dmem_addr  = rs_val;
  assign dmem_wdata = rd_val;
  // halted rises while the HALT word sits in EXEC, so the HALT instruction costs only
  // its fetch cycle in the cycle count.
  assign halted     = (state_q == StHalt) || ((state_q == StExec) && is_halt);
  assign pc_out     = pc_q;

`ifdef MC_CORE_PERF_EN
  logic        retire;
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  assign retire = ((state_q == StExec) && (is_halt || !is_mem_op)) ||
                  ((state_q == StMem) && dmem_ack);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (!halted && (cycle_cnt_q != '1)) begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      end
      if (retire && (instr_cnt_q != '1)) begin
        instr_cnt_q <= instr_cnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_core.sv
// Testbench for mc_core: directed vector table, hand-written multi-cycle sequences and random
// programs checked against an instruction-level reference model.
module tb_mc_core;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam logic [8:0] HaltW = 9'h1FF;

  logic          clk;
  logic          rst_n;
  logic          imem_req, imem_ack;
  logic [AW-1:0] imem_addr;
  logic [8:0]    imem_data;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          halted;
  logic [AW-1:0] pc_out;
`ifdef MC_CORE_PERF_EN
  logic [31:0]   cycle_cnt, instr_cnt;
`endif

  mc_core #(.DW(DW), .AW(AW), .NREG(8)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .halted     (halted),
    .pc_out     (pc_out)
`ifdef MC_CORE_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories, responder configuration and observed traffic.
  logic [8:0]  imem [64];
  logic [7:0]  dmem [256];
  int          dwait_cfg = 0;
  bit          rnd_wait  = 0;
  int          wait_total, unstable, overlap, last_hold;
  int          fetch_q[$];
  logic [15:0] store_q[$];
  int          exp_fetch[$];
  logic [15:0] exp_store[$];

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  initial begin : imem_resp
    bit busy;
    int left;
    busy = 0; left = 0;
    imem_ack = 1'b0; imem_data = '0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (imem_req && dmem_req) overlap++;
      if (imem_req) begin
        if (!busy) begin
          busy = 1;
          left = rnd_wait ? int'($urandom_range(0, 2)) : 0;
          wait_total += left;
        end
        if (left == 0) begin
          imem_ack  = 1'b1;
          imem_data = imem[imem_addr];
          fetch_q.push_back(int'(imem_addr));
          busy = 0;
        end else left--;
      end else busy = 0;
    end
  end

  initial begin : dmem_resp
    bit busy;
    int left, hold;
    logic [7:0] a0, d0;
    logic w0;
    busy = 0; left = 0; hold = 0; a0 = '0; d0 = '0; w0 = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (dmem_req) begin
        if (!busy) begin
          busy = 1;
          left = rnd_wait ? int'($urandom_range(0, 2)) : dwait_cfg;
          wait_total += left;
          hold = 0; a0 = dmem_addr; w0 = dmem_we; d0 = dmem_wdata;
        end
        hold++;
        if (dmem_addr !== a0 || dmem_we !== w0 || dmem_wdata !== d0) unstable++;
        if (left == 0) begin
          dmem_ack = 1'b1;
          if (dmem_we) begin
            dmem[dmem_addr] = dmem_wdata;
            store_q.push_back({dmem_addr, dmem_wdata});
          end else dmem_rdata = dmem[dmem_addr];
          last_hold = hold;
          busy = 0;
        end else left--;
      end else busy = 0;
    end
  end

  // Reset the core, release it mid-phase and count clock edges until halted.
  task automatic run(output int cyc);
    rst_n = 1'b0;
    fetch_q.delete(); store_q.delete();
    wait_total = 0; unstable = 0; overlap = 0; last_hold = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc = 0;
    while (halted !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (halted !== 1'b1) begin
      nvec++; nmis++;
      $display("FAIL run_timeout: halted=%b after %0d cycles, want 1", halted, cyc);
    end
  endtask

  task automatic check_perf(input string nm, input int ni, input int cyc);
`ifdef MC_CORE_PERF_EN
    @(posedge clk); #1;
    chk({nm, "_instr_cnt"}, instr_cnt, ni);
    chk({nm, "_cycle_cnt"}, cycle_cnt, cyc);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_instr_frozen"}, instr_cnt, ni);
    chk({nm, "_cycle_frozen"}, cycle_cnt, cyc);
`else
    if (ni < 0 || cyc < 0) $display("%s: negative count", nm);
`endif
  endtask

  // Instruction-level reference: executes imem on a copy of dmem.
  task automatic model_run(output int cycles, output int pc_end);
    logic [7:0] r [8];
    logic [7:0] m [256];
    logic [8:0] w;
    int pc;
    int op, rd, rs;
    m = dmem;
    for (int i = 0; i < 8; i++) r[i] = '0;
    exp_fetch.delete(); exp_store.delete();
    pc = 0; cycles = 0;
    for (int step = 0; step < 500; step++) begin
      exp_fetch.push_back(pc);
      w = imem[pc];
      if (w == HaltW) begin
        cycles += 1;
        break;
      end
      op = int'(w[8:6]); rd = int'(w[5:3]); rs = int'(w[2:0]);
      case (op)
        0: r[rd] = r[rd] + r[rs];
        1: r[rd] = r[rd] - r[rs];
        2: r[rd] = r[rd] & r[rs];
        3: r[rd] = r[rd] ^ r[rs];
        4: r[rd] = r[rd] + 8'(rs);
        5: r[rd] = m[r[rs]];
        6: begin
          m[r[rs]] = r[rd];
          exp_store.push_back({r[rs], r[rd]});
        end
        default: ;
      endcase
      if (op == 7 && r[0] == 0) pc = int'(w[5:0]);
      else pc = (pc + 1) % 64;
      cycles += (op == 5 || op == 6) ? 3 : 2;
    end
    pc_end = pc;
  endtask

  function automatic bit fetch_match();
    if (fetch_q.size() != exp_fetch.size()) return 0;
    foreach (fetch_q[k]) if (fetch_q[k] != exp_fetch[k]) return 0;
    return 1;
  endfunction

  function automatic bit store_match();
    if (store_q.size() != exp_store.size()) return 0;
    foreach (store_q[k]) if (store_q[k] !== exp_store[k]) return 0;
    return 1;
  endfunction

  function automatic logic [8:0] enc(input int op, input int rd, input int rs);
    return {3'(op), 3'(rd), 3'(rs)};
  endfunction

  function automatic logic [8:0] bz(input int t);
    return {3'b111, 6'(t)};
  endfunction

  typedef struct {
    string       name;
    logic [8:0]  prog [16];
    int          dwait;
    int          nst;
    logic [15:0] first_st;
    logic [15:0] last_st;
    int          exp_pc;
    int          exp_cyc;
    int          ninstr;
  } vec_t;

  vec_t        vecs[$];
  logic [8:0]  prog_q[$];

  task automatic addv(input string nm, input int dw, input int nst, input logic [15:0] fst,
                      input logic [15:0] lst, input int pc, input int cyc, input int ni);
    vec_t v;
    v.name = nm;
    for (int k = 0; k < 16; k++) v.prog[k] = (k < prog_q.size()) ? prog_q[k] : HaltW;
    v.dwait = dw; v.nst = nst; v.first_st = fst; v.last_st = lst;
    v.exp_pc = pc; v.exp_cyc = cyc; v.ninstr = ni;
    vecs.push_back(v);
  endtask

  initial begin
    int cyc, ecyc, epc, k, n, op;

    // Reset values and first fetch request.
    rst_n = 1'b0;
    for (int a = 0; a < 64; a++) imem[a] = HaltW;
    #3;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc_out", pc_out, 0);
`ifdef MC_CORE_PERF_EN
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_instr_cnt", instr_cnt, 0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("first_imem_req", imem_req, 1);
    chk("first_imem_addr", imem_addr, 0);

    // Directed table: program, expected stores, final PC and cycles to halt.
    prog_q = '{enc(4, 1, 5), enc(4, 1, 7)};
    addv("addi_halt", 0, 0, 16'h0, 16'h0, 2, 5, 3);
    prog_q = '{enc(4, 1, 5), enc(4, 1, 7), enc(6, 1, 0)};
    addv("addi_sum", 0, 1, 16'h000C, 16'h000C, 3, 8, 4);
    prog_q = '{enc(4, 2, 1), enc(1, 1, 2), enc(4, 1, 1), enc(6, 1, 2)};
    addv("addi_wrap", 0, 1, 16'h0100, 16'h0100, 4, 10, 5);
    prog_q = '{enc(4, 3, 1), enc(1, 2, 3), enc(6, 2, 3)};
    addv("sub_wrap", 0, 1, 16'h01FF, 16'h01FF, 3, 8, 4);
    prog_q = '{enc(4, 2, 7), enc(4, 2, 7), enc(4, 2, 2), enc(4, 3, 5), enc(0, 3, 3),
               enc(0, 3, 3), enc(4, 3, 1), enc(0, 3, 3), enc(0, 3, 3), enc(4, 3, 1),
               enc(0, 3, 3), enc(4, 3, 1), enc(6, 3, 2), enc(5, 4, 2), enc(6, 4, 1)};
    addv("st_ld_wait", 3, 2, 16'h10AB, 16'h00AB, 15, 43, 16);
    prog_q = '{bz(32)};
    addv("bz_taken", 0, 0, 16'h0, 16'h0, 32, 3, 2);
    prog_q = '{enc(4, 0, 1), bz(32), enc(6, 0, 0)};
    addv("bz_not_taken", 0, 1, 16'h0101, 16'h0101, 3, 8, 4);
    prog_q = '{enc(4, 1, 6), enc(4, 2, 3), enc(2, 1, 2), enc(4, 3, 5), enc(3, 3, 2),
               enc(6, 3, 1)};
    addv("and_xor", 0, 1, 16'h0206, 16'h0206, 6, 14, 7);

    foreach (vecs[i]) begin
      for (int a = 0; a < 64; a++) imem[a] = (a < 16) ? vecs[i].prog[a] : HaltW;
      for (int a = 0; a < 256; a++) dmem[a] = 8'(a) ^ 8'h5A;
      rnd_wait = 0; dwait_cfg = vecs[i].dwait;
      run(cyc);
      chk({vecs[i].name, "_pc"}, pc_out, vecs[i].exp_pc);
      chk({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cyc);
      chk({vecs[i].name, "_nstores"}, store_q.size(), vecs[i].nst);
      if (vecs[i].nst > 0 && store_q.size() > 0) begin
        chk({vecs[i].name, "_first_store"}, store_q[0], vecs[i].first_st);
        chk({vecs[i].name, "_last_store"}, store_q[store_q.size() - 1], vecs[i].last_st);
        chk({vecs[i].name, "_req_hold"}, last_hold, vecs[i].dwait + 1);
      end
      chk({vecs[i].name, "_unstable"}, unstable, 0);
      chk({vecs[i].name, "_req_overlap"}, overlap, 0);
      check_perf(vecs[i].name, vecs[i].ninstr, vecs[i].exp_cyc);
    end

    // PC wraps from 63 to 0.
    for (int a = 0; a < 64; a++) imem[a] = HaltW;
    imem[0] = bz(62); imem[62] = enc(4, 0, 1); imem[63] = enc(4, 1, 2); imem[1] = enc(6, 1, 0);
    rnd_wait = 0; dwait_cfg = 0;
    run(cyc);
    exp_fetch = '{0, 62, 63, 0, 1, 2};
    exp_store = '{16'h0102};
    chk("wrap_fetch_trace", fetch_match(), 1);
    chk("wrap_store", store_match(), 1);
    chk("wrap_cycles", cyc, 12);

    // Reset during a wait-stated store abandons it; the re-run starts clean.
    for (int a = 0; a < 64; a++) imem[a] = HaltW;
    imem[0] = enc(4, 1, 5); imem[1] = enc(6, 1, 1);
    dwait_cfg = 10;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    k = 0;
    while (dmem_req !== 1'b1 && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
    chk("midrst_mem_reached", dmem_req, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_dmem_req", dmem_req, 0);
    chk("midrst_imem_req", imem_req, 0);
    chk("midrst_dmem_we", dmem_we, 0);
    chk("midrst_pc", pc_out, 0);
    chk("midrst_halted", halted, 0);
    dwait_cfg = 0;
    run(cyc);
    exp_fetch = '{0, 1, 2};
    exp_store = '{16'h0505};
    chk("midrst_refetch", fetch_match(), 1);
    chk("midrst_store", store_match(), 1);

    // Random forward-branching programs against the reference model, random wait states.
    for (int p = 0; p < 25; p++) begin
      n = int'($urandom_range(4, 20));
      for (int a = 0; a < 64; a++) imem[a] = HaltW;
      for (int a = 0; a < n; a++) begin
        op = int'($urandom_range(0, 7));
        if (op == 7) imem[a] = bz(int'($urandom_range(a + 1, n)));
        else imem[a] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
      for (int a = 0; a < 256; a++) dmem[a] = 8'($urandom);
      model_run(ecyc, epc);
      rnd_wait = 1;
      run(cyc);
      chk("rnd_fetch_trace", fetch_match(), 1);
      chk("rnd_stores", store_match(), 1);
      chk("rnd_pc", pc_out, epc);
      chk("rnd_cycles", cyc, ecyc + wait_total);
      chk("rnd_unstable", unstable, 0);
      chk("rnd_req_overlap", overlap, 0);
      check_perf("rnd", exp_fetch.size(), ecyc + wait_total);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
